// File: rtl/uart_rx_io.sv
// UART receiver: 2-flop input synchronizer, 8N1 frame decoder and a
// first-word fall-through receive FIFO with sticky overrun reporting.
module uart_rx_io #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       ovr_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW    = $clog2(CLKS_PER_BIT + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta_q, rxs_q;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          brk_q, brk_d;
    logic          push_q, push_d;
    logic          fe_q, fe_d;
    logic          tick;

    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]       mem_q [DEPTH];
    logic             empty, full, pop, wr_en, ovr_set;
    logic             overrun_q;

    assign tick = (timer_q == TW'(1));

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        brk_d   = brk_q;
        push_d  = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    timer_d = HALF_BIT;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else if (!rxs_q) begin
                    state_d = S_DATA;
                    timer_d = FULL_BIT;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    timer_d = FULL_BIT;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                // A bad stop bit parks here until the line returns high (break hold-off).
                if (brk_q) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                        brk_d   = 1'b0;
                    end
                end else if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else if (rxs_q) begin
                    push_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fe_d  = 1'b1;
                    brk_d = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            brk_q     <= 1'b0;
            push_q    <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            brk_q     <= brk_d;
            push_q    <= push_d;
            fe_q      <= fe_d;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop     = rd_en && !empty;
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ovr_set)      overrun_q <= 1'b1;
            else if (ovr_clr) overrun_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
    end

    assign rx_data   = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign rx_valid  = !empty;
    assign fifo_full = full;
    assign frame_err = fe_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_io.sv
// Directed bench for uart_rx_io: table of single frames plus hand-written
// glitch, break, overrun, simultaneous push/pop and mid-frame reset sequences.
module tb_uart_rx_io;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n, rx, rd_en, ovr_clr;
    logic [7:0] rx_data;
    logic       rx_valid, fifo_full, frame_err, overrun;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int fe_wide  = 0;
    logic fe_prev = 1'b0;

    uart_rx_io #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .ovr_clr(ovr_clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .fifo_full(fifo_full),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (frame_err && fe_prev) fe_wide++;
        fe_prev = frame_err;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, rx_valid, 1'b1);
        check({name, "_data"}, rx_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int fe0;
        logic [7:0] d7e;
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0;
        d7e = 8'h7E;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 0};
        vecs[4] = '{8'hC3, 1'b0, 1'b0, 1};

        idle(4);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_data", rx_data, 8'h00);
        rst_n = 1'b1;
        idle(2 * CPB);
        check("idle_valid", rx_valid, 1'b0);

        // rd_en while empty must not move pointers
        rd_en = 1'b1; idle(3); rd_en = 1'b0;
        check("empty_pop_valid", rx_valid, 1'b0);

        for (int v = 0; v < 5; v++) begin
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            idle(2 * CPB);
            check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].exp_fe);
            if (vecs[v].exp_valid) begin
                pop_check($sformatf("vec%0d", v), vecs[v].data);
                check($sformatf("vec%0d_after_pop", v), rx_valid, 1'b0);
            end
        end

        // short start glitch
        fe0 = fe_cnt;
        rx = 1'b0; idle(4); rx = 1'b1;
        idle(3 * CPB);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_fe", fe_cnt - fe0, 0);
        send_frame(8'h42, 1'b1);
        idle(CPB);
        pop_check("post_glitch", 8'h42);

        // bad stop followed by a long break
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0; idle(40); rx = 1'b1;
        idle(2 * CPB);
        check("brk_fe", fe_cnt - fe0, 1);
        check("brk_valid", rx_valid, 1'b0);
        send_frame(8'h11, 1'b1);
        idle(CPB);
        pop_check("post_brk", 8'h11);
        check("post_brk_empty", rx_valid, 1'b0);

        // five back-to-back frames into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_frame(i[7:0], 1'b1);
        idle(CPB);
        check("ovr_full", fifo_full, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i), i[7:0]);
        check("ovr_empty", rx_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);

        // push and pop in the same cycle while full (push lands on edge 156 after the start bit)
        for (int i = 1; i <= 4; i++) send_frame(i[7:0], 1'b1);
        idle(CPB);
        check("pp_full", fifo_full, 1'b1);
        fork
            send_frame(8'h06, 1'b1);
            begin
                idle(155);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        idle(CPB);
        check("pp_ovr", overrun, 1'b0);
        check("pp_still_full", fifo_full, 1'b1);
        pop_check("pp_pop2", 8'h02);
        pop_check("pp_pop3", 8'h03);
        pop_check("pp_pop4", 8'h04);
        pop_check("pp_pop6", 8'h06);
        check("pp_empty", rx_valid, 1'b0);

        // reset in the middle of data bit 3 of 0x7E
        rx = 1'b0; idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = d7e[i];
            idle(CPB);
        end
        rx = d7e[3]; idle(CPB / 2);
        rst_n = 1'b0; rx = 1'b1; idle(4);
        check("mid_rst_valid", rx_valid, 1'b0);
        rst_n = 1'b1;
        idle(12 * CPB);
        check("mid_rst_no_partial", rx_valid, 1'b0);
        send_frame(8'h81, 1'b1);
        idle(CPB);
        pop_check("mid_rst_81", 8'h81);
        check("mid_rst_one_entry", rx_valid, 1'b0);

        check("fe_single_cycle", fe_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are >=4 and even.
REQ-002 SHALL have parameter FIFO_AW, default 2, meaning receive FIFO address width, so depth is 2**FIFO_AW.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rd_en, input, 1 bit: pops the FIFO head when rx_valid=1.
REQ-007 SHALL have port ovr_clr, input, 1 bit: clears overrun.
REQ-008 SHALL have port rx_data, output, 8 bits: FIFO head data (first-word fall-through).
REQ-009 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-010 SHALL have port fifo_full, output, 1 bit: FIFO holds 2**FIFO_AW entries.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is lost to a full FIFO.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (initialised to 1); all decoding uses the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-timer counter and a 3-bit bit index.
REQ-015 IDLE: when rxs=0, SHALL go to START and load the timer for CLKS_PER_BIT/2 cycles.
REQ-016 START: at timer expiry, SHALL resample rxs; if 0, go to DATA with the timer reloaded to CLKS_PER_BIT; if 1 (glitch), return to IDLE without a FIFO push or error.
REQ-017 DATA: at each expiry, SHALL shift rxs into the shift register LSB-first; after bit index 7, go to STOP.
REQ-018 Sample points: data bit i is sampled CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT cycles after the falling edge is seen on rxs; the stop bit is sampled at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
REQ-019 STOP, on sampling rxs=1: SHALL push the byte into the FIFO in the next cycle, then return to IDLE.
REQ-020 STOP, on sampling rxs=0: SHALL pulse frame_err for exactly 1 cycle, discard the byte, and return to IDLE only after rxs=1 (line-break hold-off).
REQ-021 A push attempted while fifo_full=1 and rd_en=0 SHALL drop the byte and set overrun; FIFO contents SHALL be unchanged.
REQ-022 Push and pop in the same cycle while full SHALL both succeed, with no overrun.
REQ-023 Push and pop in the same cycle while not empty SHALL keep the entry count unchanged.
REQ-024 rd_en while rx_valid=0 SHALL be ignored; pointers SHALL NOT move.
REQ-025 rx_valid SHALL rise in the cycle after the push cycle; rx_data SHALL be valid whenever rx_valid=1.
REQ-026 FIFO read and write pointers SHALL have FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1); full and empty are derived from the pointer MSB.
REQ-027 If ovr_clr and an overrun-setting event occur in the same cycle, set SHALL win.
REQ-028 A new start bit SHALL be accepted immediately after a stop bit, so back-to-back frames are received with no idle gap required.

Reset
REQ-029 While rst_n=0 at a clk edge, SHALL force: FSM=IDLE, synchronizer=1, FIFO pointers=0, rx_valid=0, fifo_full=0, frame_err=0, overrun=0, rx_data=8'h00.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no partial byte is pushed after reset release.
REQ-031 After reset release, the FSM SHALL remain in IDLE until the first falling edge on rxs.

Verification
REQ-032 Frame 0xA5 with correct stop, CLKS_PER_BIT=16 -> rx_valid=1, rx_data=8'hA5, frame_err never asserted; rd_en for 1 cycle -> rx_valid=0.
REQ-033 Start low for only 4 cycles, then high -> no push, no frame_err, FSM back in IDLE.
REQ-034 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0; line held low 40 cycles then high, then frame 0x11 -> rx_data=8'h11.
REQ-035 Five frames 0x01..0x05 back-to-back with no reads, depth 4 -> fifo_full=1, overrun=1; pops return 01,02,03,04; ovr_clr -> overrun=0.
REQ-036 rst_n low at data bit 3 of frame 0x7E, released, then frame 0x81 -> only 8'h81 appears; the FIFO holds exactly 1 entry.
